// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame buffer: the acquisition side fills one byte bank while the
// downstream reader drains the other; banks swap once a full frame meets an idle reader.
module frame_buffer_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_VALID,
  input  logic [7:0]        WR_DATA,
  input  logic              WR_LAST,
  output logic              WR_READY,
  input  logic              READ_NEXT,
  input  logic              FRAME_DONE,
  output logic [7:0]        RD_DATA,
  output logic [ADDR_W:0]   FRAME_LENGTH,
  output logic              FRAME_VALID,
  output logic              OVERFLOW,
  output logic [1:0]        DBG_STATE
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} w_state_t;
  typedef enum logic {R_EMPTY = 1'b0, R_ACTIVE = 1'b1} r_state_t;

  w_state_t          w_state_q;
  r_state_t          r_state_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   wr_count_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        rd_data_q;
  logic [ADDR_W:0]   frame_len_q;
  logic              frame_valid_q;
  logic              overflow_q;
  logic              fd_prev_q;

  logic [7:0] mem_q [0:2*DEPTH-1];

  logic              swap;
  logic              release_evt;
  logic              wr_ready;
  logic              accept;
  logic              wr_sel_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_ptr_d;
  logic              wr_end;
  logic [ADDR_W:0]   wr_len;
  logic              rd_can_adv;

  // Write handshake: a beat transfers on a cycle where WR_VALID and WR_READY are
  // both high; WR_VALID with WR_READY low loses the byte and raises OVERFLOW.
  // A beat arriving in the swap cycle lands at address 0 of the freshly freed bank.
  always_comb begin
    swap        = (w_state_q == W_FULL) && (r_state_q == R_EMPTY);
    release_evt = (r_state_q == R_ACTIVE) && FRAME_DONE && !fd_prev_q;
    wr_ready    = !RESET && ((w_state_q == W_FILL) || swap);
    accept      = WR_VALID && wr_ready;
    wr_sel_bank = swap ? ~wr_bank_q : wr_bank_q;
    wr_addr     = swap ? '0 : wr_ptr_q;
    wr_ptr_d    = wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    wr_end      = WR_LAST || (&wr_addr);
    wr_len      = {1'b0, wr_addr} + {{ADDR_W{1'b0}}, 1'b1};
    rd_can_adv  = ({1'b0, rd_addr_q} + {{ADDR_W{1'b0}}, 1'b1}) < frame_len_q;
  end

  always_ff @(posedge CLK) begin
    if (accept) mem_q[{wr_sel_bank, wr_addr}] <= WR_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      w_state_q     <= W_FILL;
      r_state_q     <= R_EMPTY;
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      wr_count_q    <= '0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      fd_prev_q     <= 1'b1;
    end else begin
      fd_prev_q <= FRAME_DONE;
      if (WR_VALID && !wr_ready) overflow_q <= 1'b1;

      if (accept) begin
        wr_ptr_q  <= wr_ptr_d;
        w_state_q <= wr_end ? W_FULL : W_FILL;
        if (wr_end) wr_count_q <= wr_len;
      end else if (swap) begin
        wr_ptr_q  <= '0;
        w_state_q <= W_FILL;
      end
      if (swap) wr_bank_q <= ~wr_bank_q;

      // Swap needs R_EMPTY and release needs R_ACTIVE, so they never coincide.
      if (swap) begin
        r_state_q     <= R_ACTIVE;
        rd_addr_q     <= '0;
        frame_len_q   <= wr_count_q;
        frame_valid_q <= 1'b1;
      end else if (release_evt) begin
        r_state_q     <= R_EMPTY;
        frame_valid_q <= 1'b0;
      end else if ((r_state_q == R_ACTIVE) && READ_NEXT && rd_can_adv) begin
        rd_addr_q <= rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end

      // Only a presented frame is ever read, so stale bank contents never reach RD_DATA.
      if (r_state_q == R_ACTIVE) rd_data_q <= mem_q[{~wr_bank_q, rd_addr_q}];
    end
  end

  assign WR_READY     = wr_ready;
  assign RD_DATA      = rd_data_q;
  assign FRAME_LENGTH = frame_len_q;
  assign FRAME_VALID  = frame_valid_q;
  assign OVERFLOW     = overflow_q;
  assign DBG_STATE    = {w_state_q == W_FULL, r_state_q == R_ACTIVE};

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with small banks (ADDR_W=3, 8 bytes each).
module tb_frame_buffer_ctrl;

  localparam int ADDR_W = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              WR_VALID = 1'b0;
  logic [7:0]        WR_DATA = 8'h00;
  logic              WR_LAST = 1'b0;
  logic              WR_READY;
  logic              READ_NEXT = 1'b0;
  logic              FRAME_DONE = 1'b0;
  logic [7:0]        RD_DATA;
  logic [ADDR_W:0]   FRAME_LENGTH;
  logic              FRAME_VALID;
  logic              OVERFLOW;
  logic [1:0]        DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  frame_buffer_ctrl #(.ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .WR_VALID     (WR_VALID),
    .WR_DATA      (WR_DATA),
    .WR_LAST      (WR_LAST),
    .WR_READY     (WR_READY),
    .READ_NEXT    (READ_NEXT),
    .FRAME_DONE   (FRAME_DONE),
    .RD_DATA      (RD_DATA),
    .FRAME_LENGTH (FRAME_LENGTH),
    .FRAME_VALID  (FRAME_VALID),
    .OVERFLOW     (OVERFLOW),
    .DBG_STATE    (DBG_STATE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_beat(input logic [7:0] d, input logic last);
    WR_VALID = 1'b1;
    WR_DATA  = d;
    WR_LAST  = last;
    tick();
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"},  32'(WR_READY), 0);
    check({tag, "_rd_data"},   32'(RD_DATA), 0);
    check({tag, "_frame_len"}, 32'(FRAME_LENGTH), 0);
    check({tag, "_frame_vld"}, 32'(FRAME_VALID), 0);
    check({tag, "_overflow"},  32'(OVERFLOW), 0);
    check({tag, "_state"},     32'(DBG_STATE), 0);
  endtask

  initial begin
    // Clock/reset
    #2;
    check_reset_outputs("por");
    tick();
    RESET = 1'b0;
    #1;
    check("ready_after_reset", 32'(WR_READY), 1);

    // Four-byte frame, WR_LAST on the final byte
    write_beat(8'h11, 1'b0);
    write_beat(8'h22, 1'b0);
    write_beat(8'h33, 1'b0);
    write_beat(8'h44, 1'b1);
    check("full_pending_state", 32'(DBG_STATE), 32'h2);
    check("ready_in_swap",      32'(WR_READY), 1);
    check("valid_before_swap",  32'(FRAME_VALID), 0);
    tick();
    check("swap_frame_valid", 32'(FRAME_VALID), 1);
    check("swap_frame_len",   32'(FRAME_LENGTH), 4);
    check("swap_state",       32'(DBG_STATE), 32'h1);
    check("rd_before_latency", 32'(RD_DATA), 0);
    tick();
    check("rd_byte0", 32'(RD_DATA), 32'h11);

    // Five READ_NEXT pulses, saturating at the last byte
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
    for (int i = 0; i < 6; i++) begin
      READ_NEXT = (i < 5);
      tick();
      check($sformatf("rd_seq_%0d", i), 32'(RD_DATA), 32'(exp_q.pop_front()));
    end
    READ_NEXT = 1'b0;
    check("len_held_a", 32'(FRAME_LENGTH), 4);

    // Fill the write bank to depth with no WR_LAST while the reader holds frame A
    for (int i = 0; i < 8; i++) write_beat(8'hA0 + 8'(i), 1'b0);
    check("auto_full_state", 32'(DBG_STATE), 32'h3);
    check("not_ready_full",  32'(WR_READY), 0);
    WR_VALID = 1'b1;
    WR_DATA  = 8'hFF;
    #1;
    check("refused_ready", 32'(WR_READY), 0);
    tick();
    WR_VALID = 1'b0;
    check("overflow_set", 32'(OVERFLOW), 1);
    tick();
    check("overflow_sticky", 32'(OVERFLOW), 1);
    check("valid_while_full", 32'(FRAME_VALID), 1);

    // FRAME_DONE rise releases; the swap follows with a beat in that cycle
    FRAME_DONE = 1'b1;
    tick();
    check("release_valid",  32'(FRAME_VALID), 0);
    check("release_len",    32'(FRAME_LENGTH), 4);
    check("release_state",  32'(DBG_STATE), 32'h2);
    check("release_ready",  32'(WR_READY), 1);
    write_beat(8'h5A, 1'b0);
    check("swap2_valid", 32'(FRAME_VALID), 1);
    check("swap2_len",   32'(FRAME_LENGTH), 8);
    check("swap2_state", 32'(DBG_STATE), 32'h1);

    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA7, 8'hA7};
    for (int i = 0; i < 10; i++) begin
      READ_NEXT = 1'b1;
      tick();
      check($sformatf("rd_b_%0d", i), 32'(RD_DATA), 32'(exp_q.pop_front()));
    end
    READ_NEXT = 1'b0;
    check("done_level_no_release", 32'(FRAME_VALID), 1);

    // Mid-frame reset: write pointer at 3, reader active
    write_beat(8'h5B, 1'b0);
    write_beat(8'h5C, 1'b0);
    check("pre_reset_state", 32'(DBG_STATE), 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    RESET = 1'b0;
    #1;
    check("ready_after_rst2", 32'(WR_READY), 1);

    // In R_EMPTY: READ_NEXT, bare WR_LAST and a FRAME_DONE rise do nothing
    READ_NEXT = 1'b1;
    WR_LAST   = 1'b1;
    tick();
    FRAME_DONE = 1'b0;
    tick();
    FRAME_DONE = 1'b1;
    tick();
    check("idle_state",     32'(DBG_STATE), 0);
    check("idle_valid",     32'(FRAME_VALID), 0);
    check("idle_rd_data",   32'(RD_DATA), 0);
    check("idle_frame_len", 32'(FRAME_LENGTH), 0);
    READ_NEXT  = 1'b0;
    WR_LAST    = 1'b0;
    FRAME_DONE = 1'b0;

    // First post-reset frame starts at address 0
    write_beat(8'h01, 1'b0);
    write_beat(8'h02, 1'b1);
    tick();
    check("post_rst_len",   32'(FRAME_LENGTH), 2);
    check("post_rst_valid", 32'(FRAME_VALID), 1);
    tick();
    check("post_rst_byte0", 32'(RD_DATA), 32'h01);
    READ_NEXT = 1'b1;
    tick();
    READ_NEXT = 1'b0;
    tick();
    check("post_rst_byte1", 32'(RD_DATA), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
